// File: rtl/mm_seq.sv
// -----------------------------------------------------------------------------
// mm_seq: requester-side sequencer for the Montgomery multiplier (mm).
//
// Accepts one operation from the ECC ALU, hands registered operands to the mm,
// waits for mm completion (with a timeout), then applies the final conditional
// subtraction.  The mm result lies in [0, 2*PRIME); the value returned on res_o
// is fully reduced into [0, PRIME).
//   MUL       (op_i=0): res = a * b * R^-1 mod p
//   FROM_MONT (op_i=1): res = a * 1 * R^-1 mod p       with R = 2^REG_SIZE
//
// Ports
//   clk         in   1         clock
//   reset_n     in   1         asynchronous active-low reset
//   req_i       in   1         op request, accepted only while busy_o = 0
//   op_i        in   1         0 = MUL, 1 = FROM_MONT (sampled with req_i)
//   opa_i       in   REG_SIZE  operand A, sampled on acceptance
//   opb_i       in   REG_SIZE  operand B, ignored for FROM_MONT
//   busy_o      out  1         high from the cycle after acceptance through DONE
//   done_o      out  1         one-cycle pulse, res_o / err_o valid
//   err_o       out  1         one-cycle pulse together with done_o on timeout
//   res_o       out  REG_SIZE  reduced result, held until the next done_o
//   mm_start_o  out  1         one-cycle start pulse to the mm
//   mm_opa_o    out  REG_SIZE  registered A to the mm, stable START..DONE
//   mm_opb_o    out  REG_SIZE  registered B to the mm (1 for FROM_MONT)
//   mm_p_i      in   REG_SIZE  mm product
//   mm_ready_i  in   1         mm idle/complete (still high in the START cycle)
// -----------------------------------------------------------------------------
module mm_seq #(
    parameter int                  REG_SIZE = 384,
    parameter logic [REG_SIZE-1:0] PRIME    = 384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF,
    parameter int                  TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_i,
    input  logic                op_i,
    input  logic [REG_SIZE-1:0] opa_i,
    input  logic [REG_SIZE-1:0] opb_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [REG_SIZE-1:0] res_o,
    output logic                mm_start_o,
    output logic [REG_SIZE-1:0] mm_opa_o,
    output logic [REG_SIZE-1:0] mm_opb_o,
    input  logic [REG_SIZE-1:0] mm_p_i,
    input  logic                mm_ready_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_REDUCE,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [REG_SIZE-1:0] opa_q;
    logic [REG_SIZE-1:0] opb_q;
    logic [REG_SIZE-1:0] mm_p_q;
    logic [REG_SIZE-1:0] res_q;
    logic                err_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic                timeout_hit;

    logic [REG_SIZE:0]   diff;
    logic [REG_SIZE-1:0] reduced;

    // Last WAIT cycle that may still see mm_ready_i before giving up; WAIT
    // therefore lasts at most TIMEOUT cycles.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // One extra bit so the borrow out of the subtraction doubles as the
    // "mm_p < PRIME" compare.  Inputs >= 2*PRIME are out of contract and only
    // get one subtraction.
    assign diff    = {1'b0, mm_p_q} - {1'b0, PRIME};
    assign reduced = diff[REG_SIZE] ? mm_p_q : diff[REG_SIZE-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        busy_o     = 1'b1;
        mm_start_o = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (req_i) state_nxt = S_START;
            end
            S_START: begin
                // mm_ready_i is still the stale "idle" level here; ignore it.
                mm_start_o = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (mm_ready_i)       state_nxt = S_REDUCE;
                else if (timeout_hit) state_nxt = S_DONE;
            end
            S_REDUCE: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o    = 1'b1;
                err_o     = err_q;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: the wide operand/result registers are reset on purpose: the mm
    // operand and result ports must read zero while reset_n is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            mm_p_q   <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        opa_q    <= opa_i;
                        opb_q    <= op_i ? REG_SIZE'(1) : opb_i;
                        err_q    <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (mm_ready_i) begin
                        mm_p_q <= mm_p_i;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                            res_q <= '0;
                        end
                    end
                end
                S_REDUCE: begin
                    res_q <= reduced;
                end
                default: ;
            endcase
        end
    end

    assign res_o    = res_q;
    assign mm_opa_o = opa_q;
    assign mm_opb_o = opb_q;

endmodule

// File: tb/tb_mm_seq.sv
// -----------------------------------------------------------------------------
// tb_mm_seq: self-checking bench for mm_seq.  A behavioural mm (radix-2
// Montgomery, or a fixed-value stub, or a hung unit) answers the sequencer;
// expected results come from modular arithmetic on wide integers.
// -----------------------------------------------------------------------------
module tb_mm_seq;

    localparam int W  = 384;
    localparam int TO = 64;
    localparam logic [W-1:0] P = 384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;

    logic         clk;
    logic         reset_n;
    logic         req_i;
    logic         op_i;
    logic [W-1:0] opa_i;
    logic [W-1:0] opb_i;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic [W-1:0] res_o;
    logic         mm_start_o;
    logic [W-1:0] mm_opa_o;
    logic [W-1:0] mm_opb_o;
    logic [W-1:0] mm_p_i;
    logic         mm_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    // mm model controls: 0 = real Montgomery, 1 = stub value, 2 = never ready
    int           mm_mode  = 0;
    int           mm_lat   = 0;
    logic [W-1:0] stub_val = '0;
    logic [W-1:0] mm_res;

    logic [W-1:0] r_mod_p;
    logic [W-1:0] r2_mod_p;

    mm_seq #(.REG_SIZE(W), .PRIME(P), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_i      (req_i),
        .op_i       (op_i),
        .opa_i      (opa_i),
        .opb_i      (opb_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .res_o      (res_o),
        .mm_start_o (mm_start_o),
        .mm_opa_o   (mm_opa_o),
        .mm_opb_o   (mm_opb_o),
        .mm_p_i     (mm_p_i),
        .mm_ready_i (mm_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Radix-2 Montgomery product a*b*2^-W mod p, left in [0, 2p) like the real
    // mm, but folded below 2^W so it fits the product port.
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, P};
            t = t >> 1;
        end
        if (t[W+1:W] != 2'b00) t = t - {2'b00, P};
        return t[W-1:0];
    endfunction

    // Behavioural mm: ready stays high through START, drops after the start
    // edge, and comes back high so that exactly mm_lat WAIT cycles see it low.
    initial begin
        mm_ready_i = 1'b1;
        mm_p_i     = '0;
        forever begin
            @(negedge clk);
            if (mm_start_o) begin
                if (mm_mode == 2) begin
                    @(posedge clk); #1;
                    mm_ready_i = 1'b0;
                    for (int k = 0; k < TO + 40 && !done_o && reset_n; k++) @(negedge clk);
                    mm_ready_i = 1'b1;
                end else begin
                    mm_res = (mm_mode == 0) ? mont(mm_opa_o, mm_opb_o) : stub_val;
                    if (mm_lat == 0) begin
                        mm_p_i     = mm_res;
                        mm_ready_i = 1'b1;
                    end else begin
                        @(posedge clk); #1;
                        mm_ready_i = 1'b0;
                        repeat (mm_lat + 1) @(negedge clk);
                        mm_p_i     = mm_res;
                        mm_ready_i = 1'b1;
                    end
                end
            end
        end
    end

    // Issues one request and follows it to done_o.  lat counts clock edges from
    // the accepting edge to the edge after which done_o is high.
    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic err, output int lat,
                          output logic s_start, output logic [W-1:0] s_opa,
                          output logic [W-1:0] s_opb, output logic stable);
        int           k;
        logic [W-1:0] res0;
        req_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
        k = 0;
        while (k < 10) begin
            @(posedge clk); #1; k++;
            if (busy_o) break;
        end
        n_checks++;
        if (!busy_o) begin
            n_fail++;
            $display("FAIL accept: busy_o=%b after %0d cycles, required 1", busy_o, k);
        end
        // Inputs wiggle while busy; none of it may reach the mm operands.
        req_i = 1'b0; op_i = ~op; opa_i = rand_w(); opb_i = rand_w();
        s_start = mm_start_o; s_opa = mm_opa_o; s_opb = mm_opb_o;
        res0 = res_o; stable = 1'b1; lat = 0;
        while (!done_o && lat < TO + 20) begin
            if (mm_opa_o !== s_opa || mm_opb_o !== s_opb || res_o !== res0) stable = 1'b0;
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (!done_o) begin
            n_fail++;
            $display("FAIL done_wait: done_o=%b after %0d cycles, required 1", done_o, lat);
        end
        res = res_o; err = err_o;
        if (mm_opa_o !== s_opa || mm_opb_o !== s_opb) stable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        req_i = 1'b0; op_i = 1'b0; opa_i = '0; opb_i = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if ({busy_o, done_o, err_o, mm_start_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/err/start=%b, required 0000",
                     {busy_o, done_o, err_o, mm_start_o});
        end
        n_checks++;
        if ({res_o, mm_opa_o, mm_opb_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: res=%h opa=%h opb=%h, required 0", res_o, mm_opa_o, mm_opb_o);
        end
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if ({busy_o, done_o, mm_start_o, res_o} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b start=%b res=%h, required 0",
                     busy_o, done_o, mm_start_o, res_o);
        end
    endtask

    task automatic test_mul_real();
        logic [W-1:0] res, so, sb;
        logic         err, ss, st;
        int           lat;
        mm_mode = 0; mm_lat = 5;
        run_op(1'b0, W'(1), r2_mod_p, res, err, lat, ss, so, sb, st);
        n_checks++;
        if (res !== r_mod_p || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_r_mod_p: res=%h err=%b, required res=%h err=0", res, err, r_mod_p);
        end
        n_checks++;
        if (lat != 8) begin
            n_fail++;
            $display("FAIL mul_latency: %0d cycles, required 8", lat);
        end
        n_checks++;
        if (ss !== 1'b1 || so !== W'(1) || sb !== r2_mod_p || st !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_operands: start=%b opa=%h opb=%h stable=%b, required 1/1/R^2/1",
                     ss, so, sb, st);
        end
    endtask

    task automatic test_from_mont();
        logic [W-1:0] res, so, sb;
        logic         err, ss, st;
        int           lat;
        mm_mode = 0; mm_lat = 0;
        run_op(1'b1, r_mod_p, rand_w(), res, err, lat, ss, so, sb, st);
        n_checks++;
        if (res !== W'(1) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL from_mont_one: res=%h err=%b, required 1 / 0", res, err);
        end
        n_checks++;
        if (sb !== W'(1) || so !== r_mod_p || st !== 1'b1) begin
            n_fail++;
            $display("FAIL from_mont_opb: opb=%h opa=%h stable=%b, required opb=1 opa=%h", sb, so, st, r_mod_p);
        end
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL from_mont_l0_latency: %0d cycles, required 3", lat);
        end
        mm_lat = 2;
        run_op(1'b1, '0, rand_w(), res, err, lat, ss, so, sb, st);
        n_checks++;
        if (res !== '0 || lat != 5) begin
            n_fail++;
            $display("FAIL from_mont_zero: res=%h lat=%0d, required 0 / 5", res, lat);
        end
    endtask

    task automatic test_reduce_boundary();
        logic [W-1:0] vals [5];
        logic [W-1:0] res, so, sb, exp_res;
        logic         err, ss, st;
        int           lat;
        vals[0] = P + W'(5); vals[1] = P; vals[2] = P - W'(1); vals[3] = '0; vals[4] = '1;
        mm_mode = 1;
        for (int i = 0; i < 5; i++) begin
            stub_val = vals[i]; mm_lat = i;
            exp_res  = vals[i] % P;
            run_op(1'b0, rand_w(), rand_w(), res, err, lat, ss, so, sb, st);
            n_checks++;
            if (res !== exp_res || err !== 1'b0 || lat != i + 3) begin
                n_fail++;
                $display("FAIL reduce_%0d: res=%h err=%b lat=%0d, required res=%h err=0 lat=%0d",
                         i, res, err, lat, exp_res, i + 3);
            end
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] res, so, sb;
        logic         err, ss, st;
        int           lat;
        mm_mode = 1; mm_lat = 1; stub_val = W'(12345);
        run_op(1'b0, rand_w(), rand_w(), res, err, lat, ss, so, sb, st);
        mm_mode = 2;
        run_op(1'b0, rand_w(), rand_w(), res, err, lat, ss, so, sb, st);
        n_checks++;
        if (err !== 1'b1 || res !== '0) begin
            n_fail++;
            $display("FAIL timeout_result: err=%b res=%h, required err=1 res=0", err, res);
        end
        n_checks++;
        if (lat != TO + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: %0d cycles, required %0d", lat, TO + 1);
        end
        n_checks++;
        if (st !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_res_held: stable=%b, required 1 (res_o held until DONE)", st);
        end
        n_checks++;
        if ({busy_o, done_o, err_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_back_to_idle: busy/done/err=%b, required 000", {busy_o, done_o, err_o});
        end
    endtask

    task automatic test_back_to_back();
        int           starts, dones, cyc, start_cyc, last_done;
        logic         stable;
        logic [W-1:0] prev_opa, held;
        starts = 0; dones = 0; cyc = 0; start_cyc = 0; last_done = 0; stable = 1'b1;
        held = '0;
        mm_mode = 1; mm_lat = 3; stub_val = P + W'(77);
        prev_opa = rand_w(); opa_i = prev_opa; opb_i = rand_w(); op_i = 1'b0;
        req_i = 1'b1;
        while (dones < 3 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (mm_start_o) begin
                starts++;
                n_checks++;
                if (mm_opa_o !== prev_opa) begin
                    n_fail++;
                    $display("FAIL b2b_capture: mm_opa=%h, required %h", mm_opa_o, prev_opa);
                end
                if (dones > 0) begin
                    n_checks++;
                    if (cyc - last_done != 2) begin
                        n_fail++;
                        $display("FAIL b2b_gap: done-to-start %0d cycles, required 2", cyc - last_done);
                    end
                end
                start_cyc = cyc; held = mm_opa_o;
            end else if (busy_o && mm_opa_o !== held) begin
                stable = 1'b0;
            end
            if (done_o) begin
                dones++; last_done = cyc;
                n_checks++;
                if (res_o !== W'(77) || err_o !== 1'b0 || cyc - start_cyc != 6) begin
                    n_fail++;
                    $display("FAIL b2b_done: res=%h err=%b start-to-done=%0d, required 77/0/6",
                             res_o, err_o, cyc - start_cyc);
                end
            end
            prev_opa = rand_w(); opa_i = prev_opa;
            if (dones == 3) req_i = 1'b0;
        end
        req_i = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (mm_start_o) starts++;
        end
        n_checks++;
        if (dones != 3 || starts != 3 || stable !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_count: dones=%0d starts=%0d stable=%b, required 3/3/1", dones, starts, stable);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] res, so, sb;
        logic         err, ss, st;
        int           lat, k;
        mm_mode = 1; mm_lat = 0; stub_val = P + W'(9);
        run_op(1'b0, rand_w(), rand_w(), res, err, lat, ss, so, sb, st);
        mm_mode = 2;
        req_i = 1'b1; op_i = 1'b0; opa_i = rand_w(); opb_i = rand_w();
        k = 0;
        while (k < 10) begin
            @(posedge clk); #1; k++;
            if (busy_o) break;
        end
        req_i = 1'b0;
        repeat (5) @(posedge clk); #1;
        n_checks++;
        if (busy_o !== 1'b1 || res_o !== W'(9)) begin
            n_fail++;
            $display("FAIL pre_reset_state: busy=%b res=%h, required busy=1 res=9", busy_o, res_o);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, err_o, mm_start_o} !== 4'b0000 || {res_o, mm_opa_o, mm_opb_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: busy/done/err/start=%b res=%h opa=%h opb=%h, required all 0",
                     {busy_o, done_o, err_o, mm_start_o}, res_o, mm_opa_o, mm_opb_o);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        mm_mode = 0; mm_lat = 2;
        run_op(1'b1, r_mod_p, rand_w(), res, err, lat, ss, so, sb, st);
        n_checks++;
        if (res !== W'(1) || err !== 1'b0 || lat != 5) begin
            n_fail++;
            $display("FAIL post_reset_op: res=%h err=%b lat=%0d, required 1/0/5", res, err, lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   a, b, beff, res, so, sb;
        logic [2*W-1:0] lhs, rhs, pw;
        logic           op, err, ss, st;
        int             lat, l;
        mm_mode = 0;
        pw = {{W{1'b0}}, P};
        for (int i = 0; i < 6; i++) begin
            op = 1'($urandom_range(0, 1));
            a = rand_w() % P; b = rand_w() % P;
            l = int'($urandom_range(0, 20));
            mm_lat = l;
            beff = op ? W'(1) : b;
            run_op(op, a, b, res, err, lat, ss, so, sb, st);
            // res is correct iff res < p and res * R == a * b (mod p).
            lhs = ({{W{1'b0}}, res} << W) % pw;
            rhs = ({{W{1'b0}}, a} * {{W{1'b0}}, beff}) % pw;
            n_checks++;
            if (res >= P || lhs !== rhs || err !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_%0d_value: op=%b res=%h err=%b, required reduced Montgomery product", i, op, res, err);
            end
            n_checks++;
            if (lat != l + 3 || sb !== beff || so !== a || st !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_%0d_timing: lat=%0d opb=%h stable=%b, required lat=%0d opb=%h stable=1",
                         i, lat, sb, st, l + 3, beff);
            end
        end
    endtask

    initial begin
        logic [W:0]     r_full;
        logic [2*W-1:0] sq;
        r_full   = {1'b1, {W{1'b0}}} - {1'b0, P};
        r_mod_p  = r_full[W-1:0];
        sq       = ({{W{1'b0}}, r_mod_p} * {{W{1'b0}}, r_mod_p}) % {{W{1'b0}}, P};
        r2_mod_p = sq[W-1:0];

        test_reset();
        test_mul_real();
        test_from_mont();
        test_reduce_boundary();
        test_timeout();
        test_back_to_back();
        test_reset_mid_op();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
